wb_ext_sequencer: RTL

//   Registered Wishbone fabric between the PicoRV32 external slave port (slv_ext_*) and

---
 rtl/wb_ext_pkg.sv | 30 +++
 rtl/wb_seq_timeout.sv | 42 ++++
 rtl/wb_ext_sequencer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_ext_pkg.sv
// -----------------------------------------------------------------------------
// wb_ext_pkg
//   Shared definitions for the external Wishbone sequencer:
//     - seq_state_t     : sequencer state encoding (IDLE / ACCESS / RESP)
//     - ADR_LSB, ADR_W  : position and width of the slave-select address field
//     - ERR_DATA_DEFAULT: read data returned when a hung access is aborted
//     - SLV_*           : slave index assignment on the external port
// -----------------------------------------------------------------------------
package wb_ext_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } seq_state_t;

    localparam int ADR_LSB = 2;
    localparam int ADR_W   = 4;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    localparam int NSLV_DEFAULT = 5;

    localparam int SLV_VOICE = 0;
    localparam int SLV_US1   = 1;
    localparam int SLV_RGB   = 2;
    localparam int SLV_US2   = 3;
    localparam int SLV_TEMP  = 4;

endpackage

// File: rtl/wb_seq_timeout.sv
// -----------------------------------------------------------------------------
// wb_seq_timeout
//   Access watchdog for wb_ext_sequencer. The counter is zeroed by 'clear'
//   (issued as the sequencer enters ACCESS) and advances on every cycle that
//   'enable' is high. 'expire' is asserted combinationally during the enabled
//   cycle in which the count has reached TIMEOUT-1, i.e. the TIMEOUT-th cycle
//   spent waiting.
//
//   Ports
//     clk_in     in  1  system clock
//     resetn_in  in  1  synchronous, active-low reset
//     clear      in  1  zero the counter
//     enable     in  1  count this cycle
//     expire     out 1  TIMEOUT-th enabled cycle since clear
// -----------------------------------------------------------------------------
module wb_seq_timeout #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk_in,
    input  logic resetn_in,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk_in) begin
        if (!resetn_in) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expire = enable && (count_reg == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/wb_ext_sequencer.sv
// -----------------------------------------------------------------------------
// wb_ext_sequencer
//   Registered Wishbone fabric between the CPU external slave port and NSLV
//   peripheral slaves. One transaction at a time: a rising master strobe is
//   latched, decoded from adr[5:2] (indices >= NSLV go to slave NSLV-1) and
//   presented to exactly one slave with a one-hot strobe. The selected slave's
//   ack/rdata is captured and returned to the master as a one-cycle ack.
//
//   Optional feature macro: WB_SEQ_TIMEOUT_EN
//     defined   : an access that waits TIMEOUT cycles without ack is aborted,
//                 returns ERR_DATA and sets the sticky err_o flag.
//     undefined : ACCESS waits indefinitely, err_o is tied low.
//
//   Ports
//     clk_in, resetn_in           clock, synchronous active-low reset
//     m_cyc_i/m_stb_i/m_we_i      master cycle, strobe, write enable
//     m_adr_i/m_wdata_i/m_sel_i   master address (bits [5:2] decoded), data, byte sel
//     m_ack_o/m_rdata_o           one-cycle ack and read data to master
//     s_stb_o/s_cyc_o             one-hot slave strobe / cycle (identical)
//     s_we_o/s_adr_o/s_wdata_o/s_sel_o  latched request, shared by all slaves
//     s_ack_i/s_rdata_i           per-slave ack, packed per-slave read data
//     err_o                       sticky timeout flag
// -----------------------------------------------------------------------------
module wb_ext_sequencer
    import wb_ext_pkg::*;
#(
    parameter int NSLV = NSLV_DEFAULT
`ifdef WB_SEQ_TIMEOUT_EN
    , parameter int          TIMEOUT  = 1024
    , parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
`endif
) (
    input  logic               clk_in,
    input  logic               resetn_in,
    input  logic               m_stb_i,
    input  logic               m_cyc_i,
    input  logic               m_we_i,
    input  logic [31:0]        m_adr_i,
    input  logic [31:0]        m_wdata_i,
    input  logic [3:0]         m_sel_i,
    output logic               m_ack_o,
    output logic [31:0]        m_rdata_o,
    output logic [NSLV-1:0]    s_stb_o,
    output logic [NSLV-1:0]    s_cyc_o,
    output logic               s_we_o,
    output logic [ADR_W-1:0]   s_adr_o,
    output logic [31:0]        s_wdata_o,
    output logic [3:0]         s_sel_o,
    input  logic [NSLV-1:0]    s_ack_i,
    input  logic [32*NSLV-1:0] s_rdata_i,
    output logic               err_o
);

    localparam int IDX_W = (NSLV > 1) ? $clog2(NSLV) : 1;

    seq_state_t state_reg, state_next;

    logic             stb_q_reg;
    logic             we_reg;
    logic [ADR_W-1:0] adr_reg;
    logic [31:0]      wdata_reg;
    logic [3:0]       sel_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             stb_active_reg;
    logic             ack_reg;
    logic [31:0]      rdata_reg;

    logic             request;
    logic [ADR_W-1:0] adr_field;
    logic [IDX_W-1:0] idx_next;
    logic             ack_hit;
    logic             expire;
    logic [31:0]      slave_rdata;
    logic             in_access;

    logic             start;
    logic             stb_set;
    logic             done_ok;
    logic             done_err;

    // Only the slave-select field of the address is used here.
    logic unused_adr_bits;
    assign unused_adr_bits = ^{m_adr_i[31:ADR_LSB+ADR_W], m_adr_i[ADR_LSB-1:0]};

    // Rising-edge request: a strobe held across transactions never re-triggers.
    assign request   = m_cyc_i & m_stb_i & ~stb_q_reg;
    assign adr_field = m_adr_i[ADR_LSB +: ADR_W];
    assign idx_next  = (32'(adr_field) >= 32'(NSLV)) ? IDX_W'(NSLV - 1) : IDX_W'(adr_field);

    // Acks only count once our strobe is actually on the bus, and only from
    // the selected slave.
    assign ack_hit     = stb_active_reg & s_ack_i[idx_reg];
    assign slave_rdata = s_rdata_i[32*idx_reg +: 32];
    assign in_access   = (state_reg == ST_ACCESS);

`ifdef WB_SEQ_TIMEOUT_EN
    wb_seq_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_in    (clk_in),
        .resetn_in (resetn_in),
        .clear     (start),
        .enable    (in_access),
        .expire    (expire)
    );
`else
    assign expire = 1'b0;
`endif

    // Next-state and control decode
    always_comb begin
        state_next = state_reg;
        start      = 1'b0;
        stb_set    = 1'b0;
        done_ok    = 1'b0;
        done_err   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (request) begin
                    start      = 1'b1;
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // A slave ack in the expiry cycle takes priority over the abort.
                if (ack_hit) begin
                    done_ok    = 1'b1;
                    state_next = ST_RESP;
                end else if (expire) begin
                    done_err   = 1'b1;
                    state_next = ST_RESP;
                end else if (!stb_active_reg) begin
                    stb_set = 1'b1;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!resetn_in) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Request latch, strobe and response registers
    always_ff @(posedge clk_in) begin
        if (!resetn_in) begin
            stb_q_reg      <= 1'b0;
            we_reg         <= 1'b0;
            adr_reg        <= '0;
            wdata_reg      <= '0;
            sel_reg        <= '0;
            idx_reg        <= '0;
            stb_active_reg <= 1'b0;
            ack_reg        <= 1'b0;
            rdata_reg      <= '0;
        end else begin
            stb_q_reg <= m_stb_i;
            // Ack is issued from the registered RESP state so the master sees
            // it one cycle after the slave ack was sampled.
            ack_reg   <= (state_reg == ST_RESP);
            if (start) begin
                we_reg         <= m_we_i;
                adr_reg        <= adr_field;
                wdata_reg      <= m_wdata_i;
                sel_reg        <= m_sel_i;
                idx_reg        <= idx_next;
                stb_active_reg <= 1'b0;
            end
            if (stb_set) begin
                stb_active_reg <= 1'b1;
            end
            if (done_ok) begin
                stb_active_reg <= 1'b0;
                rdata_reg      <= slave_rdata;
            end
`ifdef WB_SEQ_TIMEOUT_EN
            if (done_err) begin
                stb_active_reg <= 1'b0;
                rdata_reg      <= ERR_DATA;
            end
`endif
        end
    end

`ifdef WB_SEQ_TIMEOUT_EN
    logic err_reg;

    always_ff @(posedge clk_in) begin
        if (!resetn_in) begin
            err_reg <= 1'b0;
        end else if (done_err) begin
            err_reg <= 1'b1;
        end
    end

    assign err_o = err_reg;
`else
    assign err_o = 1'b0;
`endif

    generate
        for (genvar gi = 0; gi < NSLV; gi++) begin : g_strobe
            assign s_stb_o[gi] = stb_active_reg && (idx_reg == IDX_W'(gi));
        end
    endgenerate

    assign s_cyc_o   = s_stb_o;
    assign s_we_o    = we_reg;
    assign s_adr_o   = adr_reg;
    assign s_wdata_o = wdata_reg;
    assign s_sel_o   = sel_reg;
    assign m_ack_o   = ack_reg;
    assign m_rdata_o = rdata_reg;

endmodule
